// File: rtl/l1_mac_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// l1_mac_engine : 32-lane layer-1 MAC (pixels x weights + bias), ReLU/saturate
// Rev 1.0
// ============================================================================
module l1_mac_engine #(
  parameter int N_IN = 784
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [31:0]   ctr1,
  input  logic [1023:0] w1_bus,
  input  logic [7:0]    pix_data,
  output logic          busy,
  output logic          done,
  output logic [1023:0] h_bus
);

  localparam int LANES = 32;
  localparam int CW    = 10;
  localparam int PW    = 41;
  localparam int AW    = 52;

  localparam logic [CW-1:0]        LAST_ADDR = CW'(N_IN);
  localparam logic [CW-1:0]        PRE_LAST  = CW'(N_IN - 1);
  localparam logic signed [AW-1:0] H_MAX     = 52'sh0_0000_7FFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]  ctr_q, ctr_d;
  logic           addr_vld_q, addr_vld_d;
  logic           data_vld_q, data_vld_d;
  logic           bias_q, bias_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           clear_acc;
  logic [1023:0]  h_q, h_d;

  logic signed [AW-1:0]       acc_q [LANES];
  logic signed [AW-1:0]       acc_d [LANES];
  logic [LANES-1:0][PW-1:0]   prod_bus;
  logic [1023:0]              sat_bus;
  logic signed [8:0]          mul_op;

  // The bias word is scaled by one; pixel values are always non-negative.
  assign mul_op = bias_q ? 9'sd1 : $signed({1'b0, pix_data});

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic signed [PW-1:0] w_ext;
      logic signed [PW-1:0] op_ext;
      logic signed [PW-1:0] prod;

      assign w_ext       = PW'($signed(w1_bus[32*g +: 32]));
      assign op_ext      = PW'(mul_op);
      assign prod        = w_ext * op_ext;
      assign prod_bus[g] = prod;

      assign sat_bus[32*g +: 32] = acc_q[g][AW-1]    ? 32'd0 :
                                   (acc_q[g] > H_MAX) ? 32'h7FFF_FFFF :
                                                        acc_q[g][31:0];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    addr_vld_d = 1'b0;
    clear_acc  = 1'b0;
    done_d     = 1'b0;
    h_d        = h_q;
    // Read data lags its address by one edge.
    data_vld_d = addr_vld_q;
    bias_d     = addr_vld_q && (ctr_q == LAST_ADDR);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          ctr_d      = '0;
          addr_vld_d = 1'b1;
          clear_acc  = 1'b1;
        end
      end
      S_RUN: begin
        addr_vld_d = 1'b1;
        ctr_d      = ctr_q + 1'b1;
        if (ctr_q == PRE_LAST) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave once the bias read has been issued and accumulated.
        if (!addr_vld_q && !data_vld_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          h_d     = sat_bus;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ctr_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        ctr_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    for (int n = 0; n < LANES; n++) begin
      acc_d[n] = acc_q[n];
      if (clear_acc) begin
        acc_d[n] = '0;
      end else if (data_vld_q) begin
        acc_d[n] = acc_q[n] + AW'($signed(prod_bus[n]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ctr_q      <= '0;
      addr_vld_q <= 1'b0;
      data_vld_q <= 1'b0;
      bias_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      h_q        <= '0;
      for (int n = 0; n < LANES; n++) begin
        acc_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      addr_vld_q <= addr_vld_d;
      data_vld_q <= data_vld_d;
      bias_q     <= bias_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      h_q        <= h_d;
      for (int n = 0; n < LANES; n++) begin
        acc_q[n] <= acc_d[n];
      end
    end
  end

  assign ctr1  = {{(32-CW){1'b0}}, ctr_q};
  assign busy  = busy_q;
  assign done  = done_q;
  assign h_bus = h_q;

endmodule
`default_nettype wire

// File: tb/tb_l1_mac_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_l1_mac_engine : directed + random checks against a 64-bit reference model
// Rev 1.0
// ============================================================================
module tb_l1_mac_engine;

  localparam int N_IN = 784;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   ctr1;
  logic [1023:0] w1_bus = '0;
  logic [7:0]    pix_data = '0;
  logic          busy;
  logic          done;
  logic [1023:0] h_bus;

  logic [1023:0] w_mem   [0:N_IN];
  logic [7:0]    pix_mem [0:N_IN];

  int vectors    = 0;
  int miscompares = 0;

  l1_mac_engine #(.N_IN(N_IN)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ctr1     (ctr1),
    .w1_bus   (w1_bus),
    .pix_data (pix_data),
    .busy     (busy),
    .done     (done),
    .h_bus    (h_bus)
  );

  always #5 clk = ~clk;

  // Registered-read memory: data for the address seen at an edge appears after it.
  always @(posedge clk) begin
    w1_bus   <= w_mem[ctr1[9:0]];
    pix_data <= pix_mem[ctr1[9:0]];
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_h(input string tag, input logic [1023:0] exp);
    for (int n = 0; n < 32; n++) begin
      chk($sformatf("%s.h%0d", tag, n), 64'(h_bus[32*n +: 32]), 64'(exp[32*n +: 32]));
    end
  endtask

  function automatic logic [1023:0] ref_h();
    logic [1023:0] r;
    longint s;
    r = '0;
    for (int n = 0; n < 32; n++) begin
      s = 0;
      for (int k = 0; k < N_IN; k++) begin
        s += longint'($signed(w_mem[k][32*n +: 32])) * longint'(pix_mem[k]);
      end
      s += longint'($signed(w_mem[N_IN][32*n +: 32]));
      if (s < 0)                     r[32*n +: 32] = 32'd0;
      else if (s > 64'sd2147483647)  r[32*n +: 32] = 32'h7FFF_FFFF;
      else                           r[32*n +: 32] = s[31:0];
    end
    return r;
  endfunction

  // Wait for IDLE, then present start for one sampling edge.
  task automatic go(input bit keep_start);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_start) start = 1'b0;
    chk("start.ctr1", 64'(ctr1), 64'd0);
    chk("start.busy", 64'(busy), 64'd1);
  endtask

  // Counts edges after the start edge until done; checks the address sequence.
  task automatic wait_done(input bit poke, output int edges);
    int  gaps;
    bit  seen;
    gaps  = 0;
    seen  = 1'b0;
    edges = 0;
    while (!seen && edges < 2000) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges <= N_IN && ctr1 !== 32'(edges)) gaps++;
      if (done === 1'b1) seen = 1'b1;
      if (poke) start = (edges < N_IN - 4) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    chk("done.seen", 64'(seen), 64'd1);
    chk("ctr1.gaps", 64'(gaps), 64'd0);
    chk("done.latency", 64'(edges), 64'd787);
  endtask

  task automatic after_done(input string tag, input logic [1023:0] exp);
    chk_h(tag, exp);
    chk({tag, ".ctr1_hold"}, 64'(ctr1), 64'(N_IN));
    chk({tag, ".busy_done"}, 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    chk({tag, ".busy_idle"}, 64'(busy), 64'd0);
    chk({tag, ".ctr1_idle"}, 64'(ctr1), 64'd0);
    chk_h({tag, ".stable"}, exp);
  endtask

  initial begin : stim
    logic [1023:0] exp;
    int            edges;

    rst   = 1'b1;
    start = 1'b0;
    for (int k = 0; k <= N_IN; k++) begin
      w_mem[k]   = '0;
      pix_mem[k] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.ctr1", 64'(ctr1), 64'd0);
    chk_h("rst", '0);
    @(negedge clk);
    rst = 1'b0;

    // Zero weights, bias 5, random pixels
    for (int k = 0; k <= N_IN; k++) begin
      pix_mem[k] = 8'($urandom);
      for (int n = 0; n < 32; n++) w_mem[k][32*n +: 32] = (k == N_IN) ? 32'd5 : 32'd0;
    end
    exp = '0;
    for (int n = 0; n < 32; n++) exp[32*n +: 32] = 32'd5;
    go(1'b0);
    wait_done(1'b0, edges);
    after_done("bias5", exp);

    // Unit weights and pixels; junk pixel at the bias address must be ignored
    for (int k = 0; k <= N_IN; k++) begin
      pix_mem[k] = (k == N_IN) ? 8'hA7 : 8'd1;
      for (int n = 0; n < 32; n++) w_mem[k][32*n +: 32] = (k == N_IN) ? 32'd0 : 32'd1;
    end
    for (int n = 0; n < 32; n++) exp[32*n +: 32] = 32'd784;
    go(1'b0);
    wait_done(1'b0, edges);
    after_done("ones", exp);

    // Start re-raised on the edge that returns to IDLE is ignored
    go(1'b0);
    wait_done(1'b0, edges);
    start = 1'b1;
    after_done("ones2", exp);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("late_start.busy", 64'(busy), 64'd0);
    chk("late_start.ctr1", 64'(ctr1), 64'd0);

    // ReLU on lane 3, saturation on lane 4
    for (int k = 0; k <= N_IN; k++) begin
      pix_mem[k] = 8'd255;
      for (int n = 0; n < 32; n++) begin
        if (k == N_IN)  w_mem[k][32*n +: 32] = 32'd0;
        else if (n == 3) w_mem[k][32*n +: 32] = 32'hFFFF_FFFF;
        else if (n == 4) w_mem[k][32*n +: 32] = 32'h7FFF_FFFF;
        else            w_mem[k][32*n +: 32] = 32'($signed(12'($urandom)));
      end
    end
    exp = ref_h();
    go(1'b0);
    wait_done(1'b0, edges);
    chk("relu.h3", 64'(h_bus[32*3 +: 32]), 64'd0);
    chk("sat.h4", 64'(h_bus[32*4 +: 32]), 64'h7FFF_FFFF);
    after_done("relu_sat", exp);

    // Reset at edge 300 of RUN, then start in the first cycle after release
    go(1'b0);
    repeat (299) @(posedge clk);
    #1;
    chk("abort.ctr1_pre", 64'(ctr1), 64'd299);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.ctr1", 64'(ctr1), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk_h("abort", '0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart.busy", 64'(busy), 64'd1);
    chk("restart.ctr1", 64'(ctr1), 64'd0);
    wait_done(1'b0, edges);
    after_done("restart", exp);

    // Start held high: back-to-back evaluations with one IDLE cycle between
    go(1'b1);
    wait_done(1'b0, edges);
    after_done("b2b0", exp);
    @(posedge clk);
    #1;
    chk("b2b.busy", 64'(busy), 64'd1);
    chk("b2b.ctr1", 64'(ctr1), 64'd0);
    wait_done(1'b0, edges);
    start = 1'b0;
    after_done("b2b1", exp);

    // Random images with random start pokes during RUN
    for (int img = 0; img < 50; img++) begin
      for (int k = 0; k <= N_IN; k++) begin
        pix_mem[k] = 8'($urandom);
        for (int n = 0; n < 32; n++) begin
          w_mem[k][32*n +: 32] = (img % 2 == 0) ? 32'($urandom)
                                                : 32'($signed(12'($urandom)));
        end
      end
      exp = ref_h();
      go(1'b0);
      wait_done(1'b1, edges);
      after_done($sformatf("rand%0d", img), exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
